// File: rtl/aftab_mem_pkg.sv
// Shared types and helpers for the byte-serial memory sequencer.
package aftab_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2,
    FINISH  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Extension is taken from the top byte of the transfer size.
  function automatic logic [31:0] extend_rdata(input logic [31:0] raw,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{sext & raw[7]}}, raw[7:0]};
      SZ_HALF: r = {{16{sext & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/aftab_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module aftab_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/aftab_mem_sequencer.sv
// Splits byte/half/word requests into strobed single-byte memory accesses.
// Define AFTAB_MISALIGN_CHECK_EN to reject misaligned half/word transfers with err.
//   state   | meaning
//   IDLE    | waiting for req
//   ACCESS  | strobe high for byte[idx], waiting for rdy or timeout
//   RELEASE | strobes low, waiting for rdy to clear
//   FINISH  | done (and err) pulse, then back to IDLE
module aftab_mem_sequencer
  import aftab_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output logic                  readmem,
  output logic                  writemem,
  output logic [ADDR_WIDTH-1:0] addressBus,
  output logic [7:0]            memDataOut,
  input  logic [7:0]            memDataIn,
  input  logic                  memDataReady
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  sext_q, sext_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           raw_q, raw_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  rdy;
  logic                  start_err;
  logic [1:0]            last_idx;

  aftab_sync2 u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (memDataReady),
    .q_o   (rdy)
  );

  assign last_idx = 2'(byte_count(size_q) - 3'd1);

`ifdef AFTAB_MISALIGN_CHECK_EN
  assign start_err = (size == SZ_RSVD) || misaligned(size, addr[1:0]);
`else
  assign start_err = (size == SZ_RSVD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      idx_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raw_q   <= raw_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sext_d  = sext_q;
    size_d  = size_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          sext_d  = sext;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          idx_d   = 2'b00;
          raw_d   = '0;
          tmo_d   = TMO_LOAD;
          err_d   = start_err;
          state_d = start_err ? FINISH : ACCESS;
        end
      end
      ACCESS: begin
        if (rdy) begin
          if (!we_q) raw_d[{idx_q, 3'b000} +: 8] = memDataIn;
          state_d = RELEASE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!rdy) begin
          if (idx_q == last_idx) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 2'd1;
            tmo_d   = TMO_LOAD;
            state_d = ACCESS;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and the memory-side buses are only driven while in ACCESS.
  always_comb begin
    readmem    = 1'b0;
    writemem   = 1'b0;
    addressBus = '0;
    memDataOut = '0;
    if (state_q == ACCESS) begin
      readmem    = !we_q;
      writemem   = we_q;
      addressBus = addr_q + ADDR_WIDTH'(idx_q);
      memDataOut = wdata_q[{idx_q, 3'b000} +: 8];
    end
    busy  = (state_q != IDLE);
    done  = (state_q == FINISH);
    err   = (state_q == FINISH) && err_q;
    rdata = extend_rdata(raw_q, size_q, sext_q);
  end

endmodule

// File: tb/tb_aftab_mem_sequencer.sv
// Scoreboard bench for aftab_mem_sequencer; expectations follow AFTAB_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_aftab_mem_sequencer;
  import aftab_mem_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          done, busy, err, readmem, writemem;
  logic [AW-1:0] addressBus;
  logic [7:0]    memDataOut;
  logic [7:0]    memDataIn = 8'h00;
  logic          memDataReady = 1'b0;

  always #5 clk = ~clk;

  aftab_mem_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .err(err), .readmem(readmem), .writemem(writemem), .addressBus(addressBus),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .memDataReady(memDataReady)
  );

  typedef struct { logic e; logic [31:0] rd; int acc; int strobes; } exp_t;
  typedef struct { logic wr; logic [31:0] a; logic [7:0] d; } acc_t;

  exp_t       sb_q[$];
  acc_t       acc_q[$];
  logic [7:0] mem [0:255];
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  int         strobe_cnt = 0;
  bit         both_hi = 1'b0;
  bit         mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input logic e, input logic [31:0] rd, input int acc, input int stb);
    exp_t x;
    x.e = e; x.rd = rd; x.acc = acc; x.strobes = stb;
    sb_q.push_back(x);
  endfunction

  function automatic void acc_push(input logic wr, input logic [31:0] a, input logic [7:0] d);
    acc_t x;
    x.wr = wr; x.a = a; x.d = d;
    acc_q.push_back(x);
  endfunction

  // Byte memory: answers each new strobe once, releases ready when strobes drop.
  always @(negedge clk) begin : mem_model
    acc_t a;
    if ((readmem || writemem) && !memDataReady && !mute) begin
      acc_cnt++;
      if (acc_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_access: got addr 0x%08h, expected no access", addressBus);
      end else begin
        a = acc_q.pop_front();
        check("access_dir", {31'b0, writemem}, {31'b0, a.wr});
        check("access_addr", addressBus, a.a);
        if (a.wr) check("write_byte", {24'b0, memDataOut}, {24'b0, a.d});
      end
      if (writemem) mem[addressBus[7:0]] = memDataOut;
      else          memDataIn = mem[addressBus[7:0]];
      memDataReady = 1'b1;
    end else if (!(readmem || writemem) && memDataReady) begin
      memDataReady = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (readmem && writemem) both_hi = 1'b1;
    if (readmem || writemem) strobe_cnt++;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 err=%0b, expected no transfer", err);
      end else begin
        e = sb_q.pop_front();
        check("err", {31'b0, err}, {31'b0, e.e});
        check("rdata", rdata, e.rd);
        check("accesses", acc_cnt, e.acc);
        if (e.strobes >= 0) check("strobe_cycles", strobe_cnt, e.strobes);
        check("strobes_at_done", {30'b0, readmem, writemem}, 32'h0);
        check("busy_at_done", {31'b0, busy}, 32'h1);
        check("no_strobe_overlap", {31'b0, both_hi}, 32'h0);
      end
      acc_cnt    = 0;
      strobe_cnt = 0;
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed"}, sb_q.size(), 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_done"},  {31'b0, done}, 32'h0);
    check({name, "_busy"},  {31'b0, busy}, 32'h0);
    check({name, "_err"},   {31'b0, err}, 32'h0);
    check({name, "_strb"},  {30'b0, readmem, writemem}, 32'h0);
    check({name, "_abus"},  addressBus, 32'h0);
    check({name, "_dout"},  {24'b0, memDataOut}, 32'h0);
    check({name, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h34; mem[8'h21] = 8'h85;
    mem[8'h03] = 8'h11; mem[8'h04] = 8'h22; mem[8'h05] = 8'h33; mem[8'h06] = 8'h44;
    mem[8'h50] = 8'h80;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // word write, little-endian byte order
    acc_push(1, 32'h10, 8'hD4); acc_push(1, 32'h11, 8'hC3);
    acc_push(1, 32'h12, 8'hB2); acc_push(1, 32'h13, 8'hA1);
    exp_push(0, 32'h0, 4, -1);
    issue(1, SZ_WORD, 0, 32'h10, 32'hA1B2C3D4);
    wait_idle("word_write");
    check("mem_0x13", {24'b0, mem[8'h13]}, 32'hA1);

    acc_push(0, 32'h20, 8'h0); acc_push(0, 32'h21, 8'h0);
    exp_push(0, 32'hFFFF8534, 2, -1);
    issue(0, SZ_HALF, 1, 32'h20, 32'h0);
    wait_idle("half_read_sext");

    acc_push(0, 32'h20, 8'h0); acc_push(0, 32'h21, 8'h0);
    exp_push(0, 32'h00008534, 2, -1);
    issue(0, SZ_HALF, 0, 32'h20, 32'h0);
    wait_idle("half_read_zext");

    acc_push(0, 32'h50, 8'h0);
    exp_push(0, 32'hFFFFFF80, 1, -1);
    issue(0, SZ_BYTE, 1, 32'h50, 32'h0);
    wait_idle("byte_read_sext");

    // memory never answers: exactly TMO strobe cycles then err+done
    mute = 1'b1;
    exp_push(1, 32'h0, 0, TMO);
    issue(0, SZ_BYTE, 0, 32'h40, 32'h0);
    wait_idle("timeout");
    check("strobes_after_timeout", {30'b0, readmem, writemem}, 32'h0);
    mute = 1'b0;

`ifdef AFTAB_MISALIGN_CHECK_EN
    exp_push(1, 32'h0, 0, 0);
`else
    acc_push(0, 32'h3, 8'h0); acc_push(0, 32'h4, 8'h0);
    acc_push(0, 32'h5, 8'h0); acc_push(0, 32'h6, 8'h0);
    exp_push(0, 32'h44332211, 4, -1);
`endif
    issue(0, SZ_WORD, 0, 32'h3, 32'h0);
    wait_idle("misaligned_word_read");

`ifdef AFTAB_MISALIGN_CHECK_EN
    exp_push(1, 32'h0, 0, 0);
`else
    acc_push(1, 32'hFFFFFFFF, 8'hEF); acc_push(1, 32'h0, 8'hBE);
    exp_push(0, 32'h0, 2, -1);
`endif
    issue(1, SZ_HALF, 0, 32'hFFFFFFFF, 32'h0000BEEF);
    wait_idle("addr_wrap_write");

    // reserved size, then a req held through FINISH must be ignored
    exp_push(1, 32'h0, 0, 0);
    @(negedge clk);
    we = 1'b0; size = SZ_RSVD; sext = 1'b0; addr = 32'h60; req = 1'b1;
    @(negedge clk);
    we = 1'b1; size = SZ_WORD; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b_busy", {31'b0, busy}, 32'h0);
    check("b2b_sb_empty", sb_q.size(), 32'h0);

    // reset while the second byte of a word write is on the bus
    acc_push(1, 32'h30, 8'h88); acc_push(1, 32'h31, 8'h77);
    issue(1, SZ_WORD, 0, 32'h30, 32'h55667788);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (writemem && addressBus == 32'h31) found = 1'b1;
    end
    check("rst_second_byte_seen", {31'b0, found}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    acc_cnt = 0;
    strobe_cnt = 0;

    acc_push(0, 32'h50, 8'h0);
    exp_push(0, 32'h00000080, 1, -1);
    issue(0, SZ_BYTE, 0, 32'h50, 32'h0);
    wait_idle("after_reset_read");

    acc_push(1, 32'h70, 8'h5A); acc_push(1, 32'h71, 8'hC3);
    exp_push(0, 32'h0, 2, -1);
    issue(1, SZ_HALF, 1, 32'h70, 32'h1234C35A);
    wait_idle("after_reset_write");

    repeat (4) @(negedge clk);
    check("access_queue_drained", acc_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
